// File: rtl/fetch_mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the shared SRAM and fetch_mem_arbiter.
// The arbiter connects through the slave modport; the pipeline/SRAM side uses master.
interface fetch_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_freeze;

    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        pipe_freeze;

    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_we;
    logic [31:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  sram_rdata,
        output if_rdata, if_ready, if_freeze,
        output mem_rdata, mem_ready, pipe_freeze,
        output sram_addr, sram_wdata, sram_we
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output sram_rdata,
        input  if_rdata, if_ready, if_freeze,
        input  mem_rdata, mem_ready, pipe_freeze,
        input  sram_addr, sram_wdata, sram_we
    );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Shares one fixed-latency SRAM port between instruction fetch and the MEM stage.
// MEM wins ties; each access is IDLE -> ACC_* (SRAM_LATENCY+1 cycles) -> DONE -> IDLE.
module fetch_mem_arbiter #(
    parameter int SRAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACC_IF,
        ACC_MEM,
        DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SRAM_LATENCY);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        owner;
    logic        is_write;
    logic        flush_pend;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;

    logic        mem_req;
    logic        in_acc;
    logic        last_beat;
    logic        grant_mem;
    logic        grant_if;
    logic        if_ready_int;
    logic        mem_ready_int;

    always_comb begin
        mem_req   = bus.mem_rd_en | bus.mem_wr_en;
        in_acc    = (state == ACC_IF) || (state == ACC_MEM);
        last_beat = in_acc && (cnt == LAST_CNT);
        grant_mem = (state == IDLE) && mem_req;
        grant_if  = (state == IDLE) && !mem_req && bus.if_req && !bus.if_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_mem) begin
                    state_next = ACC_MEM;
                end else if (grant_if) begin
                    state_next = ACC_IF;
                end
            end
            ACC_IF, ACC_MEM: begin
                if (cnt == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A fetch flushed on its final ACC cycle must not overwrite the held instruction either.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 4'd0;
            owner       <= 1'b0;
            is_write    <= 1'b0;
            flush_pend  <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        cnt      <= 4'd0;
                        owner    <= 1'b1;
                        is_write <= bus.mem_wr_en;
                        addr_q   <= bus.mem_addr;
                        wdata_q  <= bus.mem_wdata;
                    end else if (grant_if) begin
                        cnt      <= 4'd0;
                        owner    <= 1'b0;
                        is_write <= 1'b0;
                        addr_q   <= bus.if_addr;
                    end
                end
                ACC_IF, ACC_MEM: begin
                    cnt <= cnt + 4'd1;
                    if ((state == ACC_IF) && bus.if_flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (last_beat && !is_write) begin
                        if (owner) begin
                            mem_rdata_q <= bus.sram_rdata;
                        end else if (!flush_pend && !bus.if_flush) begin
                            if_rdata_q <= bus.sram_rdata;
                        end
                    end
                end
                DONE: begin
                    flush_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign if_ready_int  = (state == DONE) && !owner && !flush_pend;
    assign mem_ready_int = (state == DONE) && owner;

    assign bus.if_ready    = if_ready_int;
    assign bus.mem_ready   = mem_ready_int;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_wdata  = wdata_q;
    assign bus.sram_we     = in_acc && is_write;
    assign bus.if_freeze   = bus.if_req & ~if_ready_int;
    assign bus.pipe_freeze = mem_req & ~mem_ready_int;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a transaction-timestamp model.
module tb_fetch_mem_arbiter;

    localparam int LAT = 2;

    typedef struct {
        logic        is_if;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_mem_rdata;
        int          exp_we_cycles;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] sram_mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_mem_arbiter_if bus ();

    fetch_mem_arbiter #(.SRAM_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.sram_rdata = sram_mem[bus.sram_addr[9:2]];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%08h required=%08h time=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic iflush,
                                 input logic rd, input logic wr,
                                 input logic [31:0] maddr, input logic [31:0] mwdata);
        bus.if_req    = ireq;
        bus.if_addr   = iaddr;
        bus.if_flush  = iflush;
        bus.mem_rd_en = rd;
        bus.mem_wr_en = wr;
        bus.mem_addr  = maddr;
        bus.mem_wdata = mwdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired time=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [5];
        vec_t v;
        int ready_cyc, we_cnt, if_cyc, mem_cyc;
        // random-phase requester and model state
        logic if_on, if_drop, mem_on, mem_drop, mem_rd, mem_wr, flush;
        logic [31:0] if_a, mem_a, mem_d;
        logic have_g, g_mem, g_write, g_flushed, in_acc, rdy, e_if_rdy, e_mem_rdy;
        logic [31:0] g_addr, exp_sram_addr, exp_sram_wdata, exp_if_rdata, exp_mem_rdata;
        int g, free_at, k;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10,  32'h0,        32'hE3A01005, 32'hE3A01005, 32'h0,  0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h100, 32'h0,        32'h00000055, 32'hE3A01005, 32'h55, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 32'h0BADF00D, 32'hE3A01005, 32'h55, 3};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h300, 32'h12345678, 32'h77777777, 32'hE3A01005, 32'h55, 3};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'h55, 0};

        for (int i = 0; i < 256; i++) sram_mem[i] = 32'h0;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("reset_if_ready",   32'(bus.if_ready),  32'h0);
        checkOutput("reset_mem_ready",  32'(bus.mem_ready), 32'h0);
        checkOutput("reset_sram_we",    32'(bus.sram_we),   32'h0);
        checkOutput("reset_sram_addr",  bus.sram_addr,      32'h0);
        checkOutput("reset_sram_wdata", bus.sram_wdata,     32'h0);
        checkOutput("reset_if_rdata",   bus.if_rdata,       32'h0);
        checkOutput("reset_mem_rdata",  bus.mem_rdata,      32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            sram_mem[v.addr[9:2]] = v.word;
            applyStimulus(v.is_if, v.is_if ? v.addr : 32'h0, 1'b0, v.rd, v.wr,
                          v.is_if ? 32'h0 : v.addr, v.wdata);
            #1;
            checkOutput($sformatf("v%0d_freeze_c0", i),
                        32'(v.is_if ? bus.if_freeze : bus.pipe_freeze), 32'h1);
            ready_cyc = -1;
            we_cnt = 0;
            for (int c = 1; c <= 20 && ready_cyc < 0; c++) begin
                tick();
                if (bus.sram_we) we_cnt++;
                if (c == 1 || c == LAT + 1) begin
                    checkOutput($sformatf("v%0d_sram_addr_c%0d", i, c), bus.sram_addr, v.addr);
                end
                if (c == 1 && v.wr) begin
                    checkOutput($sformatf("v%0d_sram_wdata", i), bus.sram_wdata, v.wdata);
                end
                if (v.is_if ? bus.if_ready : bus.mem_ready) begin
                    ready_cyc = c;
                    checkOutput($sformatf("v%0d_if_rdata", i),  bus.if_rdata,  v.exp_if_rdata);
                    checkOutput($sformatf("v%0d_mem_rdata", i), bus.mem_rdata, v.exp_mem_rdata);
                    checkOutput($sformatf("v%0d_other_ready", i),
                                32'(v.is_if ? bus.mem_ready : bus.if_ready), 32'h0);
                end
            end
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("v%0d_ready_cycle", i), 32'(ready_cyc), 32'(LAT + 2));
            checkOutput($sformatf("v%0d_we_cycles", i), 32'(we_cnt), 32'(v.exp_we_cycles));
            tick();
            checkOutput($sformatf("v%0d_ready_low_after", i), 32'({bus.if_ready, bus.mem_ready}), 32'h0);
        end

        // Simultaneous IF and MEM requests: MEM first, IF granted the cycle after MEM's DONE.
        sram_mem[32'h100 >> 2] = 32'h55;
        sram_mem[32'h10 >> 2]  = 32'h600DF00D;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        mem_cyc = -1;
        if_cyc = -1;
        for (int c = 1; c <= 20 && if_cyc < 0; c++) begin
            tick();
            if (bus.mem_ready && mem_cyc < 0) begin
                mem_cyc = c;
                checkOutput("sim_mem_rdata", bus.mem_rdata, 32'h55);
                applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (bus.if_ready) begin
                if_cyc = c;
                checkOutput("sim_if_rdata", bus.if_rdata, 32'h600DF00D);
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("sim_mem_ready_cycle", 32'(mem_cyc), 32'(LAT + 2));
        checkOutput("sim_if_ready_cycle",  32'(if_cyc),  32'(2 * LAT + 5));
        tick();

        // Flush in ACC cycle 2: stale fetch completes silently, re-request at 0x40 is served.
        sram_mem[32'h10 >> 2] = 32'h0F0F0F0F;
        sram_mem[32'h40 >> 2] = 32'hABCD1234;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        if_cyc = -1;
        for (int c = 1; c <= 20 && if_cyc < 0; c++) begin
            tick();
            if (bus.if_ready) begin
                if_cyc = c;
                checkOutput("flush_new_if_rdata", bus.if_rdata, 32'hABCD1234);
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if (c == 2) begin
                applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if (c == 3) begin
                applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end else if (c == LAT + 2) begin
                checkOutput("flush_if_rdata_held", bus.if_rdata, 32'h600DF00D);
                applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("flush_if_ready_cycle", 32'(if_cyc), 32'(2 * LAT + 5));
        tick();

        // Reset asserted in the second ACC_MEM cycle of a store.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF);
        tick();
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("rstmid_sram_we",    32'(bus.sram_we),   32'h0);
        checkOutput("rstmid_mem_ready",  32'(bus.mem_ready), 32'h0);
        checkOutput("rstmid_sram_addr",  bus.sram_addr,      32'h0);
        checkOutput("rstmid_sram_wdata", bus.sram_wdata,     32'h0);
        checkOutput("rstmid_if_rdata",   bus.if_rdata,       32'h0);
        checkOutput("rstmid_mem_rdata",  bus.mem_rdata,      32'h0);
        rst = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            checkOutput("rstmid_no_late_ready", 32'({bus.mem_ready, bus.sram_we}), 32'h0);
        end

        // Random traffic: the model tracks only grant timestamps and who was granted.
        for (int i = 0; i < 256; i++) sram_mem[i] = $urandom;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_on = 1'b0; if_drop = 1'b0; mem_on = 1'b0; mem_drop = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; if_a = 32'h0; mem_a = 32'h0; mem_d = 32'h0;
        have_g = 1'b0; g_mem = 1'b0; g_write = 1'b0; g_flushed = 1'b0; g_addr = 32'h0;
        g = 0; free_at = 0;
        exp_sram_addr = 32'h0; exp_sram_wdata = 32'h0; exp_if_rdata = 32'h0; exp_mem_rdata = 32'h0;

        for (int t = 0; t < 3000; t++) begin
            if (if_drop) begin
                if_on = 1'b0;
                if_drop = 1'b0;
            end else if (!if_on && $urandom_range(0, 3) == 0) begin
                if_on = 1'b1;
                if_a = $urandom;
            end
            if (mem_drop) begin
                mem_on = 1'b0;
                mem_drop = 1'b0;
            end else if (!mem_on && $urandom_range(0, 4) == 0) begin
                mem_on = 1'b1;
                k = $urandom_range(0, 7);
                mem_rd = (k < 4) || (k == 7);
                mem_wr = (k >= 4);
                mem_a = $urandom;
                mem_d = $urandom;
            end
            flush = ($urandom_range(0, 7) == 0);
            applyStimulus(if_on, if_a, flush, mem_on & mem_rd, mem_on & mem_wr, mem_a, mem_d);
            #1;

            in_acc = have_g && (t > g) && (t <= g + LAT + 1);
            rdy    = have_g && (t == g + LAT + 2);
            if (rdy && !g_write) begin
                if (g_mem) exp_mem_rdata = sram_mem[g_addr[9:2]];
                else if (!g_flushed) exp_if_rdata = sram_mem[g_addr[9:2]];
            end
            e_if_rdy  = rdy && !g_mem && !g_flushed;
            e_mem_rdy = rdy && g_mem;

            checkOutput("rnd_if_ready",    32'(bus.if_ready),    32'(e_if_rdy));
            checkOutput("rnd_mem_ready",   32'(bus.mem_ready),   32'(e_mem_rdy));
            checkOutput("rnd_sram_we",     32'(bus.sram_we),     32'(in_acc && g_write));
            checkOutput("rnd_sram_addr",   bus.sram_addr,        exp_sram_addr);
            checkOutput("rnd_sram_wdata",  bus.sram_wdata,       exp_sram_wdata);
            checkOutput("rnd_if_rdata",    bus.if_rdata,         exp_if_rdata);
            checkOutput("rnd_mem_rdata",   bus.mem_rdata,        exp_mem_rdata);
            checkOutput("rnd_if_freeze",   32'(bus.if_freeze),   32'(if_on && !e_if_rdy));
            checkOutput("rnd_pipe_freeze", 32'(bus.pipe_freeze), 32'(mem_on && !e_mem_rdy));

            if (e_if_rdy)  if_drop = 1'b1;
            if (e_mem_rdy) mem_drop = 1'b1;

            if (in_acc && !g_mem && flush) g_flushed = 1'b1;
            if (t >= free_at && (mem_on || (if_on && !flush))) begin
                have_g    = 1'b1;
                g         = t;
                free_at   = t + LAT + 3;
                g_flushed = 1'b0;
                g_mem     = mem_on;
                g_write   = mem_on && mem_wr;
                g_addr    = mem_on ? mem_a : if_a;
                exp_sram_addr = g_addr;
                if (mem_on) exp_sram_wdata = mem_d;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
